ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_ctrl_pkg.sv | 19 +
 rtl/ifetch_buf.sv | 47 ++++
 rtl/ifetch_ctrl.sv | 126 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// rtl/ifetch_ctrl_pkg.sv - shared constants and types for the instruction fetch unit
package ifetch_ctrl_pkg;

  localparam int ILEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     pc_nb;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - two-entry instruction buffer with push/pop/flush and occupancy count
module ifetch_buf
  import ifetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic rd_ptr;
  logic wr_ptr;
  logic do_push;
  logic do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // a full buffer still accepts a push when the head leaves in the same cycle
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count == 2'd0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction fetch controller: request FSM, fetch pc, redirect/drop handling
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_nb,
  output logic [31:0] if_instruction
);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, fetch_pc_nxt;
  logic [31:0]  inflight_pc;
  logic [31:0]  redir_pc_q, redir_pc_nxt;
  logic         redir_pend, redir_pend_nxt;
  logic         drop, drop_nxt;
  logic [31:0]  target;
  logic [1:0]   count;
  logic         push, pop, space_after;
  fetch_entry_t head, push_entry;

  assign target      = {redirect_pc[31:2], 2'b00};
  assign push        = (state == S_WAIT) && imem_rvalid && !drop && !redirect;
  assign pop         = if_valid && if_ready;
  assign space_after = (int'(count) + int'(push) - int'(pop)) < BUF_DEPTH;
  assign push_entry  = '{pc: inflight_pc, pc_nb: inflight_pc + 32'd4, instr: imem_rdata};

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    drop_nxt       = drop;
    redir_pend_nxt = redir_pend;
    redir_pc_nxt   = redir_pc_q;
    case (state)
      S_IDLE: if (int'(count) < BUF_DEPTH) state_nxt = S_REQ;
      S_REQ: if (imem_gnt) begin
        state_nxt = S_WAIT;
        if (redir_pend) begin
          fetch_pc_nxt   = redir_pc_q;
          drop_nxt       = 1'b1;
          redir_pend_nxt = 1'b0;
        end else begin
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      S_WAIT: if (imem_rvalid) begin
        drop_nxt  = 1'b0;
        state_nxt = (drop || space_after) ? S_REQ : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // redirect overrides whatever the normal flow decided this cycle
    if (redirect) begin
      case (state)
        S_IDLE: begin
          fetch_pc_nxt = target;
          state_nxt    = S_REQ;
        end
        S_REQ: if (imem_gnt) begin
          fetch_pc_nxt   = target;
          drop_nxt       = 1'b1;
          redir_pend_nxt = 1'b0;
        end else begin
          redir_pend_nxt = 1'b1;
          redir_pc_nxt   = target;
        end
        S_WAIT: begin
          fetch_pc_nxt = target;
          drop_nxt     = !imem_rvalid;
          if (imem_rvalid) state_nxt = S_REQ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      inflight_pc <= 32'd0;
      redir_pc_q  <= 32'd0;
      redir_pend  <= 1'b0;
      drop        <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      redir_pc_q <= redir_pc_nxt;
      redir_pend <= redir_pend_nxt;
      drop       <= drop_nxt;
      if (state == S_REQ && imem_gnt) inflight_pc <= fetch_pc;
    end
  end

  ifetch_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign imem_req       = (state == S_REQ);
  assign imem_addr      = fetch_pc;
  assign if_valid       = (count != 2'd0);
  assign if_pc          = head.pc;
  assign if_pc_nb       = head.pc_nb;
  assign if_instruction = head.instr;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_nb;
  logic [31:0] if_instruction;

  ifetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_nb       (if_pc_nb),
    .if_instruction (if_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // memory/decode environment and in-order program-stream model
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic        hold_chk;
  logic [31:0] hold_addr;
  logic [31:0] exp_pc;
  int          grants;
  int          hs;
  logic        gnt_en, ready_drv, redir_req;
  logic [31:0] redir_tgt;
  int          lat_cfg;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    if_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    pend = 1'b0; hold_chk = 1'b0; redir_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_data", if_pc | if_pc_nb | if_instruction, 32'd0);
    rst_n  = 1'b1;
    exp_pc = 32'h0;
  endtask

  // one cycle of environment activity, entered and left at a falling edge
  task automatic step();
    if (hold_chk) begin
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, hold_addr);
    end
    if (imem_req) begin
      chk("one_outstanding", {31'd0, pend}, 32'd0);
      chk("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
    end
    if (pend && pend_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      pend        = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) pend_cnt--;
    end
    imem_gnt = gnt_en;
    if (imem_req && imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat_cfg;
      grants++;
      hold_chk  = 1'b0;
    end else begin
      hold_chk  = imem_req;
      hold_addr = imem_addr;
    end
    if_ready = ready_drv;
    if (if_valid && if_ready) begin
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_pc_nb", if_pc_nb, exp_pc + 32'd4);
      chk("stream_instr", if_instruction, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      hs++;
    end
    redirect    = redir_req;
    redirect_pc = redir_tgt;
    if (redir_req) exp_pc = {redir_tgt[31:2], 2'b00};
    @(posedge clk);
    @(negedge clk);
    redirect  = 1'b0;
    redir_req = 1'b0;
  endtask

  initial begin
    int n, g0;
    logic quiet;
    grants = 0; hs = 0; lat_cfg = 0; gnt_en = 1'b0; ready_drv = 1'b0;
    redir_req = 1'b0; redir_tgt = 32'd0;

    // basic streaming then redirect while waiting on 0x8
    //          gnt   rv    rdata          rdy   rdr   rpc          req   addr         val   pc           instr
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0,       1'b0, 32'h4,       1'b0, 32'h0,       32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b1, 32'h4,       1'b1, 32'h0,       32'h1111_0000};
    tbl[4]  = '{1'b0, 1'b1, 32'h2222_0004, 1'b1, 1'b0, 32'h0,       1'b0, 32'h8,       1'b0, 32'h0,       32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       1'b1, 32'h4,       32'h2222_0004};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h100,     1'b0, 32'hC,       1'b0, 32'h0,       32'h0};
    tbl[7]  = '{1'b0, 1'b1, 32'h3333_0008, 1'b0, 1'b0, 32'h0,       1'b0, 32'h100,     1'b0, 32'h0,       32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b1, 32'h100,     1'b0, 32'h0,       32'h0};
    tbl[9]  = '{1'b0, 1'b1, 32'h4444_0100, 1'b0, 1'b0, 32'h0,       1'b0, 32'h104,     1'b0, 32'h0,       32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b1, 32'h104,     1'b1, 32'h100,     32'h4444_0100};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b1, 32'h104,     1'b0, 32'h0,       32'h0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d_pc", i), if_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_pc_nb", i), if_pc_nb, tbl[i].e_valid ? tbl[i].e_pc + 32'd4 : 32'd0);
      chk($sformatf("vec%0d_instr", i), if_instruction, tbl[i].e_instr);
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rvalid; imem_rdata = tbl[i].rdata;
      if_ready = tbl[i].ready; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      @(negedge clk);
    end

    // decode stalled: two entries fill the buffer, then one pop frees one request
    do_reset();
    gnt_en = 1'b1; lat_cfg = 0; ready_drv = 1'b0; g0 = grants;
    for (int i = 0; i < 20; i++) step();
    chk("stall_grants", grants - g0, 2);
    chk("stall_valid", {31'd0, if_valid}, 32'd1);
    chk("stall_head", if_pc, 32'h0);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) quiet = 1'b0;
      step();
    end
    chk("stall_no_req", {31'd0, quiet}, 32'd1);
    ready_drv = 1'b1; step(); ready_drv = 1'b0;
    g0 = grants;
    for (int i = 0; i < 10; i++) step();
    chk("one_pop_one_req", grants - g0, 1);
    chk("after_pop_head", if_pc, 32'h4);

    // redirect in REQ without grant: old address held, response dropped
    do_reset();
    gnt_en = 1'b1; lat_cfg = 0; ready_drv = 1'b1; n = 0;
    while (!(imem_req && imem_addr == 32'h10) && n < 60) begin step(); n++; end
    chk("reach_0x10", {31'd0, imem_req}, 32'd1);
    gnt_en = 1'b0; redir_req = 1'b1; redir_tgt = 32'h203;
    step();
    for (int i = 0; i < 3; i++) step();
    chk("held_req", {31'd0, imem_req}, 32'd1);
    chk("held_addr", imem_addr, 32'h10);
    gnt_en = 1'b1; step();
    n = 0;
    while (!imem_req && n < 20) begin step(); n++; end
    chk("redir_next_req", {31'd0, imem_req}, 32'd1);
    chk("redir_next_addr", imem_addr, 32'h200);
    g0 = hs;
    for (int i = 0; i < 10; i++) step();
    chk("redir_progress", {31'd0, hs > g0}, 32'd1);

    // address wrap at the top of the 32-bit space
    do_reset();
    gnt_en = 1'b1; lat_cfg = 0; ready_drv = 1'b0;
    redir_req = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    step();
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    n = 0;
    while (!imem_req && n < 20) begin step(); n++; end
    chk("wrap_next_addr", imem_addr, 32'h0);
    n = 0;
    while (!if_valid && n < 20) begin step(); n++; end
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_nb", if_pc_nb, 32'h0);

    // reset while waiting; stale response after release must not enqueue
    do_reset();
    gnt_en = 1'b1; lat_cfg = 3; ready_drv = 1'b0; g0 = grants; n = 0;
    while (grants == g0 && n < 10) begin step(); n++; end
    chk("rst_mid_granted", grants - g0, 1);
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; imem_gnt = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_gnt = 1'b0;
    chk("stale_no_enq", {31'd0, if_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("rel_first_valid", {31'd0, if_valid}, 32'd1);
    chk("rel_first_pc", if_pc, 32'h0);
    chk("rel_first_instr", if_instruction, mem_word(32'h0));

    // randomized traffic against the program-stream model
    do_reset();
    g0 = hs;
    for (int i = 0; i < 3000; i++) begin
      gnt_en    = ($urandom_range(0, 1) == 1);
      lat_cfg   = $urandom_range(0, 2);
      ready_drv = ($urandom_range(0, 9) < 7);
      redir_req = ($urandom_range(0, 99) < 4);
      redir_tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step();
    end
    chk("random_progress", {31'd0, (hs - g0) > 100}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
